// File: rtl/trophy_field_ctrl_pkg.sv
// trophy_pkg: shared types and constants for the trophy field controller.
//   state_t    - controller FSM states
//   LFSR_W     - width of the shared placement LFSR
//   LFSR_TAPS  - Fibonacci tap mask (taps 16,14,13,11 -> bits 15,13,12,10)
//   offboard() - all-ones sentinel of a given width (coordinate parked off the grid)
package trophy_pkg;

  typedef enum logic [1:0] {IDLE, PLACE, ACTIVE, DONE} state_t;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] offboard(input int w);
    offboard = 16'((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/trophy_field_ctrl_if.sv
// trophy_field_ctrl_if: player-position inputs and trophy-state outputs of the
// trophy field controller.
//   game_start          - single-cycle (re)start pulse
//   player_row/col      - current player cell
//   trophy_valid        - bit i: trophy i on board, uncollected
//   trophy_row/col      - packed coordinates, trophy i at [i*W +: W]
//   collected_pulse     - one cycle per collection
//   collected_cnt       - saturating collection count for this game
//   all_collected, busy - board cleared / placement in progress
// Modports: master = player/game side, slave = controller.
interface trophy_field_ctrl_if #(
  parameter int NUM_TROPHY = 3,
  parameter int ROW_W      = 5,
  parameter int COL_W      = 5,
  parameter int CNT_W      = 4
);
  logic                        game_start;
  logic [ROW_W-1:0]            player_row;
  logic [COL_W-1:0]            player_col;
  logic [NUM_TROPHY-1:0]       trophy_valid;
  logic [NUM_TROPHY*ROW_W-1:0] trophy_row;
  logic [NUM_TROPHY*COL_W-1:0] trophy_col;
  logic                        collected_pulse;
  logic [CNT_W-1:0]            collected_cnt;
  logic                        all_collected;
  logic                        busy;

  modport master (
    output game_start, player_row, player_col,
    input  trophy_valid, trophy_row, trophy_col, collected_pulse,
           collected_cnt, all_collected, busy
  );

  modport slave (
    input  game_start, player_row, player_col,
    output trophy_valid, trophy_row, trophy_col, collected_pulse,
           collected_cnt, all_collected, busy
  );
endinterface

// File: rtl/trophy_field_ctrl_lfsr.sv
// trophy_lfsr: 16-bit Fibonacci LFSR, free-running every cycle.
//   clk, rst (async, active-high, reloads SEED), out - current LFSR state
module trophy_lfsr
  import trophy_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= SEED;
    else     out <= {out[LFSR_W-2:0], ^(out & LFSR_TAPS)};
  end

endmodule

// File: rtl/trophy_field_ctrl.sv
// trophy_field_ctrl: places NUM_TROPHY trophies on distinct in-bounds cells at
// game start, tracks collection by the player, counts collections and flags a
// cleared board.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - trophy_field_ctrl_if.slave (player inputs, trophy outputs)
// Build option: TROPHY_RESPAWN_EN - a collected trophy is re-placed at once
// (single-index placement); the board is never cleared.
module trophy_field_ctrl
  import trophy_pkg::*;
#(
  parameter int                NUM_TROPHY = 3,
  parameter int                ROW_W      = 5,
  parameter int                COL_W      = 5,
  parameter int                ROWS       = 18,
  parameter int                COLS       = 26,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
  parameter int                CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  trophy_field_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_TROPHY > 1) ? $clog2(NUM_TROPHY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TROPHY - 1);

  logic [LFSR_W-1:0] lfsr;

  trophy_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  state_t                               state;
  logic [IDX_W-1:0]                     idx;
  logic [NUM_TROPHY-1:0]                valid;
  logic [NUM_TROPHY-1:0][ROW_W-1:0]     rows;
  logic [NUM_TROPHY-1:0][COL_W-1:0]     cols;
  logic                                 pulse;
  logic [CNT_W-1:0]                     cnt;
  logic                                 all_col;
  logic                                 busy;
`ifdef TROPHY_RESPAWN_EN
  logic                                 respawn;  // current PLACE fills one index only
`endif

  logic [ROW_W-1:0]      cand_row;
  logic [COL_W-1:0]      cand_col;
  logic                  cand_ok;
  logic [NUM_TROPHY-1:0] hit;
  logic [IDX_W-1:0]      hit_idx;

  assign cand_row = lfsr[ROW_W-1:0];
  assign cand_col = lfsr[ROW_W+COL_W-1:ROW_W];

  if (ROW_W + COL_W < LFSR_W) begin : g_unused
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:ROW_W+COL_W];
  end

  // Candidate acceptance and collection match; positions are kept distinct,
  // so at most one hit bit is ever set.
  always_comb begin
    cand_ok = (32'(cand_row) < ROWS) && (32'(cand_col) < COLS) &&
              !(cand_row == bus.player_row && cand_col == bus.player_col);
    hit     = '0;
    hit_idx = '0;
    for (int i = 0; i < NUM_TROPHY; i++) begin
      if (valid[i] && rows[i] == cand_row && cols[i] == cand_col) cand_ok = 1'b0;
      hit[i] = valid[i] && rows[i] == bus.player_row && cols[i] == bus.player_col;
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      valid   <= '0;
      for (int i = 0; i < NUM_TROPHY; i++) begin
        rows[i] <= ROW_W'(offboard(ROW_W));
        cols[i] <= COL_W'(offboard(COL_W));
      end
      pulse   <= 1'b0;
      cnt     <= '0;
      all_col <= 1'b0;
      busy    <= 1'b0;
`ifdef TROPHY_RESPAWN_EN
      respawn <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
      if (bus.game_start) begin
        // restart wins over any collection in the same cycle
        state   <= PLACE;
        idx     <= '0;
        valid   <= '0;
        cnt     <= '0;
        all_col <= 1'b0;
        busy    <= 1'b1;
`ifdef TROPHY_RESPAWN_EN
        respawn <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: ;
          PLACE: begin
            if (cand_ok) begin
              rows[idx]  <= cand_row;
              cols[idx]  <= cand_col;
              valid[idx] <= 1'b1;
`ifdef TROPHY_RESPAWN_EN
              if (respawn || idx == LAST_IDX) begin
                state   <= ACTIVE;
                busy    <= 1'b0;
                respawn <= 1'b0;
              end else begin
                idx <= idx + 1'b1;
              end
`else
              if (idx == LAST_IDX) begin
                state <= ACTIVE;
                busy  <= 1'b0;
              end else begin
                idx <= idx + 1'b1;
              end
`endif
            end
          end
          ACTIVE: begin
            if (|hit) begin
              valid[hit_idx] <= 1'b0;
              pulse          <= 1'b1;
              if (cnt != '1) cnt <= cnt + 1'b1;
`ifdef TROPHY_RESPAWN_EN
              state   <= PLACE;
              idx     <= hit_idx;
              respawn <= 1'b1;
              busy    <= 1'b1;
`else
              if ((valid & ~hit) == '0) begin
                state   <= DONE;
                all_col <= 1'b1;
              end
`endif
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.trophy_valid    = valid;
  assign bus.trophy_row      = rows;
  assign bus.trophy_col      = cols;
  assign bus.collected_pulse = pulse;
  assign bus.collected_cnt   = cnt;
  assign bus.all_collected   = all_col;
  assign bus.busy            = busy;

endmodule

// File: tb/tb_trophy_field_ctrl.sv
module tb_trophy_field_ctrl;
`ifdef TROPHY_RESPAWN_EN
  localparam int CW = 2;
`else
  localparam int CW = 4;
`endif

  typedef struct {
    logic [CW-1:0] cnt;
    logic [2:0]    vld;
    logic          all;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  sb_t  sb[$];

  logic [15:0] m_lfsr;
  logic [4:0]  p_row [3];
  logic [4:0]  p_col [3];
  logic [2:0]  p_vld;

  always #5 clk = ~clk;

  trophy_field_ctrl_if #(.NUM_TROPHY(3), .ROW_W(5), .COL_W(5), .CNT_W(CW)) bus ();

  trophy_field_ctrl #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= step(m_lfsr);
  end

  task automatic predict(input logic [15:0] v0, input logic [4:0] pr, input logic [4:0] pc,
                         input int first, input int last, output int n);
    logic [15:0] v;
    int          i;
    v = v0;
    i = first;
    n = 0;
    while (i <= last && n < 1000) begin
      logic [4:0] r;
      logic [4:0] c;
      bit         ok;
      r  = v[4:0];
      c  = v[9:5];
      ok = (r < 5'd18) && (c < 5'd26) && !(r == pr && c == pc);
      for (int j = 0; j < 3; j++)
        if (p_vld[j] && p_row[j] == r && p_col[j] == c) ok = 1'b0;
      if (ok) begin
        p_row[i] = r;
        p_col[i] = c;
        p_vld[i] = 1'b1;
        i++;
      end
      v = step(v);
      n++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_place(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 500) begin
      tick();
      n++;
    end
  endtask

  task automatic place_check(input string tag, input logic [4:0] pr, input logic [4:0] pc,
                             input int first, input int last);
    int n_exp;
    int n;
    predict(m_lfsr, pr, pc, first, last, n_exp);
    wait_place(n);
    chk({tag, "_cycles"}, n, n_exp);
    chk({tag, "_valid"}, bus.trophy_valid, 3'b111);
    chk({tag, "_rows"}, bus.trophy_row, {p_row[2], p_row[1], p_row[0]});
    chk({tag, "_cols"}, bus.trophy_col, {p_col[2], p_col[1], p_col[0]});
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_inbounds"}, (bus.trophy_row[i*5 +: 5] < 5'd18) && (bus.trophy_col[i*5 +: 5] < 5'd26), 1'b1);
      chk({tag, "_notplayer"}, (bus.trophy_row[i*5 +: 5] == pr) && (bus.trophy_col[i*5 +: 5] == pc), 1'b0);
      for (int j = i + 1; j < 3; j++)
        chk({tag, "_distinct"}, {bus.trophy_row[i*5 +: 5], bus.trophy_col[i*5 +: 5]} ==
                                {bus.trophy_row[j*5 +: 5], bus.trophy_col[j*5 +: 5]}, 1'b0);
    end
  endtask

  task automatic collect(input int i, input logic [CW-1:0] exp_cnt, input logic [2:0] exp_vld,
                         input logic exp_all);
    sb_t e;
    int  k;
    sb.push_back('{cnt: exp_cnt, vld: exp_vld, all: exp_all});
    bus.player_row = p_row[i];
    bus.player_col = p_col[i];
    tick();
    k = 0;
    while (bus.collected_pulse !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    chk("pulse_latency", k, 0);
    e = sb.pop_front();
    chk("coll_cnt", bus.collected_cnt, e.cnt);
    chk("coll_valid", bus.trophy_valid, e.vld);
    chk("coll_all", bus.all_collected, e.all);
    p_vld[i] = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    bus.game_start = 1'b0;
    bus.player_row = '0;
    bus.player_col = '0;

    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("rst_valid", bus.trophy_valid, 3'b000);
    chk("rst_row", bus.trophy_row, 15'h7FFF);
    chk("rst_col", bus.trophy_col, 15'h7FFF);
    chk("rst_pulse", bus.collected_pulse, 1'b0);
    chk("rst_cnt", bus.collected_cnt, {CW{1'b0}});
    chk("rst_all", bus.all_collected, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    repeat (20) begin
      tick();
      chk("idle_hold", {bus.busy, bus.trophy_valid, bus.collected_pulse}, 5'b0);
    end

    bus.game_start = 1'b1;
    tick();
    bus.game_start = 1'b0;
    chk("start_busy", bus.busy, 1'b1);
    p_vld = 3'b000;
    place_check("place1", 5'd0, 5'd0, 0, 2);

`ifndef TROPHY_RESPAWN_EN
    collect(1, 4'd1, 3'b101, 1'b0);
    repeat (3) begin
      tick();
      chk("hold_no_pulse", {bus.collected_pulse, bus.collected_cnt}, {1'b0, 4'd1});
    end
    collect(0, 4'd2, 3'b100, 1'b0);
    collect(2, 4'd3, 3'b000, 1'b1);
    repeat (50) begin
      tick();
      chk("done_hold", {bus.all_collected, bus.trophy_valid, bus.busy, bus.collected_pulse}, 6'b100000);
    end

    bus.game_start = 1'b1;
    tick();
    bus.game_start = 1'b0;
    chk("restart_busy_all", {bus.busy, bus.all_collected, bus.collected_cnt}, {1'b1, 1'b0, 4'd0});
    p_vld = 3'b000;
    place_check("place2", bus.player_row, bus.player_col, 0, 2);
    collect(1, 4'd1, 3'b101, 1'b0);
`endif

    bus.player_row = p_row[0];
    bus.player_col = p_col[0];
    bus.game_start = 1'b1;
    tick();
    bus.game_start = 1'b0;
    chk("gs_pulse", bus.collected_pulse, 1'b0);
    chk("gs_valid", bus.trophy_valid, 3'b000);
    chk("gs_cnt", bus.collected_cnt, {CW{1'b0}});
    chk("gs_busy", bus.busy, 1'b1);
    chk("gs_all", bus.all_collected, 1'b0);
    p_vld = 3'b000;
    place_check("place3", bus.player_row, bus.player_col, 0, 2);

`ifdef TROPHY_RESPAWN_EN
    for (int k = 1; k <= 5; k++) begin
      int          i;
      logic [4:0]  pr;
      logic [4:0]  pc;
      i  = k % 3;
      pr = p_row[i];
      pc = p_col[i];
      collect(i, (k >= 3) ? 2'd3 : 2'(k), 3'b111 & ~(3'b001 << i), 1'b0);
      chk("respawn_busy", bus.busy, 1'b1);
      place_check("respawn", pr, pc, i, i);
      chk("respawn_all", bus.all_collected, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
